// File: rtl/fb_pkg.sv
// Shared defaults and grant/state encoding for the frame-buffer access arbiter.
package fb_pkg;

   localparam int FB_ADDR_W     = 24;
   localparam int FB_DATA_W     = 4;
   localparam int FB_FIFO_DEPTH = 4;
   localparam int FB_WORDS_DFLT = 307200;
   localparam int FB_RD_LAT     = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_CLEAR = 2'd3
   } fb_arb_state_t;

   // Clear counter width; a single-word buffer still needs one bit.
   function automatic int fb_cnt_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of {addr,data} CPU write entries; head is visible combinationally.
module fb_wr_fifo #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [ADDR_W-1:0]        push_addr,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [ADDR_W-1:0]        head_addr,
   output logic [DATA_W-1:0]        head_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [ADDR_W+DATA_W-1:0] entries [DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic                     do_push;
   logic                     do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign {head_addr, head_data} = entries[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         entries[wr_ptr] <= {push_addr, push_data};
      end
   end

   // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads first, then clear fill, then buffered CPU writes.
//  state  | meaning
//  IDLE   | no RAM access, mem_addr/mem_wdata held
//  READ   | scan-out read issued at vga_addr
//  WRITE  | FIFO head written to RAM
//  CLEAR  | clear colour written at clr_cnt
module fb_access_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int FIFO_DEPTH = FB_FIFO_DEPTH,
   parameter int FB_WORDS   = FB_WORDS_DFLT,
   parameter int RD_LAT     = FB_RD_LAT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          vga_req,
   input  logic [ADDR_W-1:0]             vga_addr,
   output logic                          vga_rvalid,
   output logic [DATA_W-1:0]             vga_rdata,
   input  logic                          cpu_wr_valid,
   output logic                          cpu_wr_ready,
   input  logic [ADDR_W-1:0]             cpu_wr_addr,
   input  logic [DATA_W-1:0]             cpu_wr_data,
   input  logic                          clear_req,
   input  logic [DATA_W-1:0]             clear_color,
   output logic                          clear_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic                          mem_we,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata
);

   localparam int CNT_W = fb_cnt_w(FB_WORDS);

   fb_arb_state_t     state_q;
   fb_arb_state_t     state_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic              mem_we_d;
   logic [DATA_W-1:0] mem_wdata_d;

   logic [CNT_W-1:0]  clr_cnt;
   logic [DATA_W-1:0] clr_color;
   logic              clr_active;
   logic              clr_last;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   logic [RD_LAT-1:0] rv_sr;

   assign cpu_wr_ready = !fifo_full;
   assign fifo_push    = cpu_wr_valid && cpu_wr_ready;
   assign fifo_pop     = (state_d == ST_WRITE);
   assign clr_last     = (clr_cnt == CNT_W'(FB_WORDS - 1));
   assign vga_rdata    = mem_rdata;
   assign vga_rvalid   = rv_sr[RD_LAT-1];

   fb_wr_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_addr (cpu_wr_addr),
      .push_data (cpu_wr_data),
      .pop       (fifo_pop),
      .head_addr (head_addr),
      .head_data (head_data),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // CPU drain waits for clear_busy, which outlives clr_active by one cycle,
   // so no queued pixel can land before the last fill word.
   always_comb begin
      state_d     = ST_IDLE;
      mem_addr_d  = mem_addr;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata;
      if (vga_req) begin
         state_d = ST_READ;
      end else if (clr_active) begin
         state_d = ST_CLEAR;
      end else if (!clear_busy && !fifo_empty) begin
         state_d = ST_WRITE;
      end
      case (state_d)
         ST_READ: begin
            mem_addr_d = vga_addr;
         end
         ST_CLEAR: begin
            mem_addr_d  = ADDR_W'(clr_cnt);
            mem_we_d    = 1'b1;
            mem_wdata_d = clr_color;
         end
         ST_WRITE: begin
            mem_addr_d  = head_addr;
            mem_we_d    = 1'b1;
            mem_wdata_d = head_data;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         rv_sr     <= '0;
      end else begin
         state_q   <= state_d;
         mem_addr  <= mem_addr_d;
         mem_we    <= mem_we_d;
         mem_wdata <= mem_wdata_d;
         // state_q==READ is the first stage: the address is on the bus this cycle.
         rv_sr     <= RD_LAT'({rv_sr, state_q == ST_READ});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt    <= '0;
         clr_color  <= '0;
         clr_active <= 1'b0;
         clear_busy <= 1'b0;
      end else if (!clear_busy) begin
         if (clear_req) begin
            clr_cnt    <= '0;
            clr_color  <= clear_color;
            clr_active <= 1'b1;
            clear_busy <= 1'b1;
         end
      end else if (!clr_active) begin
         clear_busy <= 1'b0;
      end else if (state_d == ST_CLEAR) begin
         if (clr_last) begin
            clr_active <= 1'b0;
         end else begin
            clr_cnt <= clr_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter: vector table plus clear/reset sequences.
module tb_fb_access_arbiter;

   localparam int ADDR_W     = 24;
   localparam int DATA_W     = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int FB_WORDS   = 16;
   localparam int NVEC       = 18;

   logic              clk = 1'b0;
   logic              rst;
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_rvalid;
   logic [DATA_W-1:0] vga_rdata;
   logic              cpu_wr_valid;
   logic              cpu_wr_ready;
   logic [ADDR_W-1:0] cpu_wr_addr;
   logic [DATA_W-1:0] cpu_wr_data;
   logic              clear_req;
   logic [DATA_W-1:0] clear_color;
   logic              clear_busy;
   logic [2:0]        fifo_level;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        req;
      logic [23:0] vaddr;
      logic        wv;
      logic [23:0] waddr;
      logic [3:0]  wdat;
      logic        we;
      logic [23:0] maddr;
      logic [3:0]  mwdat;
      logic [2:0]  lvl;
      logic        rdy;
      logic        rv;
      logic [3:0]  rdata;
   } vec_t;

   vec_t       vecs [NVEC];
   logic [3:0] ram  [16];

   always #5 clk = ~clk;

   // RAM model, RD_LAT=1: data is a function of the sampled address.
   always @(posedge clk) mem_rdata <= mem_addr[3:0] ^ 4'h5;

   fb_access_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .FB_WORDS   (FB_WORDS),
      .RD_LAT     (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .vga_req      (vga_req),
      .vga_addr     (vga_addr),
      .vga_rvalid   (vga_rvalid),
      .vga_rdata    (vga_rdata),
      .cpu_wr_valid (cpu_wr_valid),
      .cpu_wr_ready (cpu_wr_ready),
      .cpu_wr_addr  (cpu_wr_addr),
      .cpu_wr_data  (cpu_wr_data),
      .clear_req    (clear_req),
      .clear_color  (clear_color),
      .clear_busy   (clear_busy),
      .fifo_level   (fifo_level),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      vga_req      = 1'b0;
      vga_addr     = '0;
      cpu_wr_valid = 1'b0;
      cpu_wr_addr  = '0;
      cpu_wr_data  = '0;
      clear_req    = 1'b0;
      clear_color  = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one clear. rd_at/cpu_at/clr2_at: number of clear writes seen before a
   // scan-out read, a CPU write to 0x7 (data C), or a second clear_req (-1 = never).
   task automatic run_clear(input string tag, input logic [3:0] color, input int rd_at,
                            input int cpu_at, input int clr2_at,
                            output int n_clear, output int n_cpu);
      int  nclr;
      int  ncpu;
      int  last_cyc;
      bit  rd_done;
      bit  cpu_done;
      bit  clr2_done;
      bit  held_chk;
      bit  rd_now;
      nclr = 0; ncpu = 0; last_cyc = -10;
      rd_done = 0; cpu_done = 0; clr2_done = 0; held_chk = 0;
      idle_inputs();
      clear_color = color;
      clear_req   = 1'b1;
      tick();
      clear_req = 1'b0;
      check({tag, "_busy_set"}, 32'(clear_busy), 32'd1);
      for (int cyc = 0; cyc < 40; cyc++) begin
         rd_now       = (nclr == rd_at) && !rd_done;
         vga_req      = rd_now;
         vga_addr     = 24'h000040;
         cpu_wr_valid = (nclr == cpu_at) && !cpu_done;
         cpu_wr_addr  = 24'h000007;
         cpu_wr_data  = 4'hC;
         clear_req    = (nclr == clr2_at) && !clr2_done;
         clear_color  = 4'hE;
         if (rd_now) rd_done = 1;
         if (cpu_wr_valid) cpu_done = 1;
         if (clear_req) clr2_done = 1;
         tick();
         if (rd_now) begin
            check({tag, "_read_we"}, 32'(mem_we), 32'd0);
            check({tag, "_read_addr"}, 32'(mem_addr), 32'h40);
         end
         if (mem_we) begin
            ram[mem_addr[3:0]] = mem_wdata;
            if (nclr < FB_WORDS) begin
               check($sformatf("%s_addr%0d", tag, nclr), 32'(mem_addr), 32'(nclr));
               check($sformatf("%s_data%0d", tag, nclr), 32'(mem_wdata), 32'(color));
               nclr++;
               if (nclr == FB_WORDS) begin
                  check({tag, "_busy_on_last"}, 32'(clear_busy), 32'd1);
                  last_cyc = cyc;
               end
            end else begin
               ncpu++;
               check({tag, "_cpu_addr"}, 32'(mem_addr), 32'h7);
               check({tag, "_cpu_data"}, 32'(mem_wdata), 32'hC);
            end
         end
         if (cyc == last_cyc + 1) check({tag, "_busy_drop"}, 32'(clear_busy), 32'd0);
         if (cpu_at >= 0 && nclr == 12 && !held_chk) begin
            check({tag, "_fifo_held"}, 32'(fifo_level), 32'd1);
            held_chk = 1;
         end
      end
      idle_inputs();
      n_clear = nclr;
      n_cpu   = ncpu;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int nclr;
      int ncpu;
      int bad;
      int nwe;
      int nbusy;

      // req vaddr wv waddr wdat | we maddr mwdat lvl rdy rv rdata
      vecs[0]  = '{1'b1, 24'h10, 1'b1, 24'h20,  4'hA, 1'b0, 24'h10,  4'h0, 3'd1, 1'b1, 1'b0, 4'h0};
      vecs[1]  = '{1'b1, 24'h11, 1'b0, 24'h0,   4'h0, 1'b0, 24'h11,  4'h0, 3'd1, 1'b1, 1'b1, 4'h5};
      vecs[2]  = '{1'b0, 24'h0,  1'b0, 24'h0,   4'h0, 1'b1, 24'h20,  4'hA, 3'd0, 1'b1, 1'b1, 4'h4};
      vecs[3]  = '{1'b0, 24'h0,  1'b0, 24'h0,   4'h0, 1'b0, 24'h20,  4'hA, 3'd0, 1'b1, 1'b0, 4'h0};
      vecs[4]  = '{1'b1, 24'h30, 1'b1, 24'h100, 4'h1, 1'b0, 24'h30,  4'hA, 3'd1, 1'b1, 1'b0, 4'h0};
      vecs[5]  = '{1'b1, 24'h31, 1'b1, 24'h101, 4'h2, 1'b0, 24'h31,  4'hA, 3'd2, 1'b1, 1'b1, 4'h5};
      vecs[6]  = '{1'b1, 24'h32, 1'b1, 24'h102, 4'h3, 1'b0, 24'h32,  4'hA, 3'd3, 1'b1, 1'b1, 4'h4};
      vecs[7]  = '{1'b1, 24'h33, 1'b1, 24'h103, 4'h4, 1'b0, 24'h33,  4'hA, 3'd4, 1'b0, 1'b1, 4'h7};
      vecs[8]  = '{1'b1, 24'h34, 1'b1, 24'h1FF, 4'hF, 1'b0, 24'h34,  4'hA, 3'd4, 1'b0, 1'b1, 4'h6};
      vecs[9]  = '{1'b0, 24'h0,  1'b0, 24'h0,   4'h0, 1'b1, 24'h100, 4'h1, 3'd3, 1'b1, 1'b1, 4'h1};
      vecs[10] = '{1'b0, 24'h0,  1'b0, 24'h0,   4'h0, 1'b1, 24'h101, 4'h2, 3'd2, 1'b1, 1'b0, 4'h0};
      vecs[11] = '{1'b0, 24'h0,  1'b0, 24'h0,   4'h0, 1'b1, 24'h102, 4'h3, 3'd1, 1'b1, 1'b0, 4'h0};
      vecs[12] = '{1'b0, 24'h0,  1'b0, 24'h0,   4'h0, 1'b1, 24'h103, 4'h4, 3'd0, 1'b1, 1'b0, 4'h0};
      vecs[13] = '{1'b0, 24'h0,  1'b0, 24'h0,   4'h0, 1'b0, 24'h103, 4'h4, 3'd0, 1'b1, 1'b0, 4'h0};
      vecs[14] = '{1'b0, 24'h0,  1'b1, 24'h200, 4'h5, 1'b0, 24'h103, 4'h4, 3'd1, 1'b1, 1'b0, 4'h0};
      vecs[15] = '{1'b0, 24'h0,  1'b1, 24'h201, 4'h6, 1'b1, 24'h200, 4'h5, 3'd1, 1'b1, 1'b0, 4'h0};
      vecs[16] = '{1'b0, 24'h0,  1'b0, 24'h0,   4'h0, 1'b1, 24'h201, 4'h6, 3'd0, 1'b1, 1'b0, 4'h0};
      vecs[17] = '{1'b0, 24'h0,  1'b0, 24'h0,   4'h0, 1'b0, 24'h201, 4'h6, 3'd0, 1'b1, 1'b0, 4'h0};

      for (int i = 0; i < 16; i++) ram[i] = 4'h0;

      // Reset in the middle of read/write/clear traffic.
      idle_inputs();
      rst = 1'b1;
      repeat (2) tick();
      rst          = 1'b0;
      vga_req      = 1'b1;
      vga_addr     = 24'h000055;
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 24'h000009;
      cpu_wr_data  = 4'h3;
      clear_color  = 4'h7;
      clear_req    = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      repeat (2) tick();
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_rvalid", 32'(vga_rvalid), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_busy", 32'(clear_busy), 32'd0);
      check("rst_ready", 32'(cpu_wr_ready), 32'd1);
      rst = 1'b0;
      idle_inputs();

      // Read priority, FIFO fill/drain ordering, push+pop at once, no bypass.
      for (int i = 0; i < NVEC; i++) begin
         vga_req      = vecs[i].req;
         vga_addr     = vecs[i].vaddr;
         cpu_wr_valid = vecs[i].wv;
         cpu_wr_addr  = vecs[i].waddr;
         cpu_wr_data  = vecs[i].wdat;
         tick();
         check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].we));
         check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
         check($sformatf("vec%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].mwdat));
         check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].lvl));
         check($sformatf("vec%0d_ready", i), 32'(cpu_wr_ready), 32'(vecs[i].rdy));
         check($sformatf("vec%0d_rvalid", i), 32'(vga_rvalid), 32'(vecs[i].rv));
         if (vecs[i].rv) check($sformatf("vec%0d_rdata", i), 32'(vga_rdata), 32'(vecs[i].rdata));
      end
      idle_inputs();
      tick();

      // Clear with a scan-out read stealing the slot at clr_cnt=5.
      run_clear("clr1", 4'h3, 5, -1, -1, nclr, ncpu);
      check("clr1_count", 32'(nclr), 32'd16);
      check("clr1_cpu_count", 32'(ncpu), 32'd0);

      // Clear with a queued CPU write to 0x7 and an ignored second clear_req.
      run_clear("clr2", 4'h9, -1, 2, 10, nclr, ncpu);
      check("clr2_count", 32'(nclr), 32'd16);
      check("clr2_cpu_count", 32'(ncpu), 32'd1);
      check("clr2_ram7", 32'(ram[7]), 32'hC);
      bad = 0;
      for (int i = 0; i < 16; i++) if (i != 7 && ram[i] !== 4'h9) bad++;
      check("clr2_ram_fill", 32'(bad), 32'd0);
      check("clr2_idle_busy", 32'(clear_busy), 32'd0);

      // Reset during a clear with two writes queued.
      idle_inputs();
      clear_color = 4'h5;
      clear_req   = 1'b1;
      tick();
      clear_req = 1'b0;
      nclr = 0;
      for (int c = 0; c < 30 && nclr < 8; c++) begin
         cpu_wr_valid = (c < 2);
         cpu_wr_addr  = 24'(32'h300 + c);
         cpu_wr_data  = 4'(c + 1);
         tick();
         if (mem_we) nclr++;
      end
      cpu_wr_valid = 1'b0;
      check("rstclr_cnt", 32'(nclr), 32'd8);
      check("rstclr_level_pre", 32'(fifo_level), 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstclr_busy", 32'(clear_busy), 32'd0);
      check("rstclr_level", 32'(fifo_level), 32'd0);
      check("rstclr_we", 32'(mem_we), 32'd0);
      check("rstclr_ready", 32'(cpu_wr_ready), 32'd1);
      nwe = 0;
      nbusy = 0;
      repeat (20) begin
         tick();
         if (mem_we) nwe++;
         if (clear_busy) nbusy++;
      end
      check("rstclr_no_writes", 32'(nwe), 32'd0);
      check("rstclr_no_busy", 32'(nbusy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
